vocab_matcher: RTL and testbench

VOCAB_MATCHER -- requirements
Module: vocab_matcher

---
 rtl/tensor_core_pkg.sv | 14 +
 rtl/vocab_matcher.sv | 132 +++++++++++++
 tb/tb_vocab_matcher.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor_core blocks.
// Holds the vocab matcher FSM encoding and the null character value.
package tensor_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COMPARE,
    DONE
  } state_e;

  localparam int NULL_CHAR = 0;

endpackage

// File: rtl/vocab_matcher.sv
// Scans a character-addressed vocabulary for a query word.
// Supports exact and prefix matching; the lowest matching entry wins.
module vocab_matcher
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int WORD_LENGTH = 3,
  parameter int VOCAB_DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(VOCAB_DEPTH*WORD_LENGTH),
  localparam int IDX_WIDTH  = $clog2(VOCAB_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
  input  logic                              prefix_mode,
  output logic                              mem_re,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy,
  output logic                              done,
  output logic                              found,
  output logic [IDX_WIDTH-1:0]              match_index
);

  localparam int CW = $clog2(WORD_LENGTH + 1);
  localparam logic [DATA_WIDTH-1:0] NUL = DATA_WIDTH'(NULL_CHAR);
  localparam logic [IDX_WIDTH-1:0] LAST_K = IDX_WIDTH'(VOCAB_DEPTH - 1);
  localparam logic [CW-1:0] LAST_C = CW'(WORD_LENGTH - 1);

  state_e                            state_q, state_d;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
  logic                              prefix_q, prefix_d;
  logic [IDX_WIDTH-1:0]              k_q, k_d;
  logic [CW-1:0]                     c_q, c_d;
  logic [ADDR_WIDTH-1:0]             base_q, base_d;
  logic                              found_q, found_d;
  logic [IDX_WIDTH-1:0]              idx_q, idx_d;

  logic [DATA_WIDTH-1:0]  qch [WORD_LENGTH];
  logic [WORD_LENGTH-1:0] last_c;

  // last_c[i]: a match on char i completes the query
  for (genvar i = 0; i < WORD_LENGTH; i++) begin : g_q
    assign qch[i] = word_q[i*DATA_WIDTH +: DATA_WIDTH];
    if (i == WORD_LENGTH - 1) begin : g_end
      assign last_c[i] = 1'b1;
    end else begin : g_mid
      assign last_c[i] = prefix_q &&
        (word_q[(i+1)*DATA_WIDTH +: DATA_WIDTH] == NUL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      prefix_q <= 1'b0;
      k_q      <= '0;
      c_q      <= '0;
      base_q   <= '0;
      found_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      prefix_q <= prefix_d;
      k_q      <= k_d;
      c_q      <= c_d;
      base_q   <= base_d;
      found_q  <= found_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    prefix_d = prefix_q;
    k_d      = k_q;
    c_d      = c_q;
    base_d   = base_q;
    found_d  = found_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          word_d   = word;
          prefix_d = prefix_mode;
          found_d  = 1'b0;
          idx_d    = '0;
          k_d      = '0;
          c_d      = '0;
          base_d   = '0;
          state_d  = (word[DATA_WIDTH-1:0] == NUL) ? DONE : FETCH;
        end
      end
      FETCH: state_d = COMPARE;
      COMPARE: begin
        if (c_q == '0 && mem_rdata == NUL) begin
          state_d = DONE;
        end else if (mem_rdata != qch[c_q]) begin
          if (k_q == LAST_K) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            c_d     = '0;
            base_d  = base_q + ADDR_WIDTH'(WORD_LENGTH);
            state_d = FETCH;
          end
        end else if (last_c[c_q] || c_q == LAST_C) begin
          found_d = 1'b1;
          idx_d   = k_q;
          state_d = DONE;
        end else begin
          c_d     = c_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_re      = (state_q == FETCH);
  assign mem_addr    = base_q + ADDR_WIDTH'(c_q);
  assign busy        = (state_q == FETCH) || (state_q == COMPARE);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign match_index = idx_q;

endmodule

// File: tb/tb_vocab_matcher.sv
// Directed and randomized checks of vocab_matcher against a
// word-level reference search over the bench-owned vocabulary.
module tb_vocab_matcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] word;
  logic        prefix_mode;
  logic        mem_re;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic        done;
  logic        found;
  logic [3:0]  match_index;

  logic [7:0] mem [48];
  int tests = 0;
  int fails = 0;
  int nreads, maxa, lasta;

  vocab_matcher dut (
    .clk(clk), .rst(rst), .start(start), .word(word),
    .prefix_mode(prefix_mode), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .found(found), .match_index(match_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_re) mem_rdata <= mem[mem_addr];

  always @(negedge clk)
    if (mem_re === 1'b1) begin
      nreads++;
      lasta = int'(mem_addr);
      if (lasta > maxa) maxa = lasta;
    end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [7:0] c0,
      input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  // Word-level search: walk entries, count characters read.
  function automatic void model(input logic [23:0] w, input bit pm,
      output bit f, output int idx, output int cyc,
      output int mx, output int nrd);
    logic [7:0] q [3];
    logic [7:0] e;
    int len;
    bit stop;
    for (int i = 0; i < 3; i++) q[i] = w[i*8 +: 8];
    f = 0; idx = 0; nrd = 0; mx = -1; cyc = 1;
    if (q[0] == 8'd0) return;
    len = 3;
    if (pm)
      for (int i = 2; i >= 1; i--)
        if (q[i] == 8'd0) len = i;
    stop = 0;
    for (int k = 0; k < 16 && !stop; k++) begin
      for (int i = 0; i < len; i++) begin
        e = mem[k*3+i];
        nrd++;
        mx = k*3 + i;
        if (i == 0 && e == 8'd0) begin stop = 1; break; end
        if (e != q[i]) break;
        if (i == len-1) begin f = 1; idx = k; stop = 1; end
      end
    end
    cyc = 1 + 2*nrd;
  endfunction

  task automatic run(input logic [23:0] w, input bit pm,
      input int poke, input string tag, output int cyc);
    bit ef;
    int eidx, ecyc, emx, enrd;
    logic fh;
    logic [3:0] ih;
    model(w, pm, ef, eidx, ecyc, emx, enrd);
    nreads = 0; maxa = -1; lasta = -1;
    word = w; prefix_mode = pm; start = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      start = (n == poke);
      if (n == poke) word = ~w;
      if (done) begin cyc = n; break; end
      if (n == 1) check({tag, "_busy"}, busy, 1);
    end
    start = 1'b0;
    check({tag, "_cycles"}, cyc, ecyc);
    check({tag, "_found"}, found, ef);
    check({tag, "_index"}, match_index, eidx);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_reads"}, nreads, enrd);
    check({tag, "_max_addr"}, maxa, emx);
    fh = found; ih = match_index;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold"}, {found, match_index}, {ef, 4'(eidx)});
  endtask

  task automatic load_common();
    for (int a = 0; a < 48; a++) mem[a] = 8'd0;
    {mem[0], mem[1], mem[2]} = {"c", "a", "t"};
    {mem[3], mem[4], mem[5]} = {"c", "a", "r"};
    {mem[6], mem[7], mem[8]} = {"d", "o", 8'd0};
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; word = '0; prefix_mode = 1'b0;
    mem_rdata = '0;
    load_common();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
      {busy, done, found, match_index, mem_re, mem_addr}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(mk("c", "a", "r"), 0, 0, "v1_car", cyc);
    check("v1_done_cycle", cyc, 13);
    check("v1_index", {found, match_index}, {1'b1, 4'd1});

    run(mk("d", "o", 0), 0, 0, "v2_do_exact", cyc);
    check("v2_do_idx", {found, match_index}, {1'b1, 4'd2});
    run(mk("d", 0, 0), 1, 0, "v2_d_prefix", cyc);
    check("v2_dp_idx", {found, match_index}, {1'b1, 4'd2});
    run(mk("d", 0, 0), 0, 0, "v2_d_exact", cyc);
    check("v2_de_found", found, 0);

    run(mk("d", "o", "g"), 0, 0, "v3_dog", cyc);
    check("v3_term_addr", lasta, 9);
    check("v3_max_addr", maxa, 9);
    check("v3_result", {found, match_index}, 0);

    run(mk(0, "a", "b"), 1, 0, "v4_null", cyc);
    check("v4_latency", cyc, 1);
    check("v4_no_read", nreads, 0);
    run(mk("c", "a", "r"), 0, 3, "v4_start_busy", cyc);
    check("v4_ignored", {found, match_index}, {1'b1, 4'd1});

    for (int k = 0; k < 16; k++) begin
      mem[k*3] = "z"; mem[k*3+1] = "z"; mem[k*3+2] = 8'("a" + k);
    end
    run(mk("z", "z", "!"), 0, 0, "v5_full", cyc);
    check("v5_last_addr", lasta, 47);
    check("v5_found", found, 0);

    load_common();
    word = mk("c", "a", "r"); prefix_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; word = mk("c", "a", "t");
    @(posedge clk); #1;
    check("v6_reset_mid",
      {busy, done, found, match_index, mem_re, mem_addr}, 0);
    @(posedge clk); #1;
    check("v6_reset_held",
      {busy, done, found, match_index, mem_re, mem_addr}, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    run(mk("c", "a", "t"), 0, 0, "v6_after", cyc);
    check("v6_after_idx", {found, match_index}, {1'b1, 4'd0});

    for (int it = 0; it < 40; it++) begin
      logic [7:0] c [3];
      for (int k = 0; k < 16; k++)
        for (int i = 0; i < 3; i++)
          mem[k*3+i] = ($urandom_range(0, 9) == 0) ? 8'd0 :
            8'("a" + $urandom_range(0, 1));
      for (int i = 0; i < 3; i++)
        c[i] = ($urandom_range(0, 4) == 0) ? 8'd0 :
          8'("a" + $urandom_range(0, 1));
      if ($urandom_range(0, 7) != 0 && c[0] == 8'd0) c[0] = "a";
      run(mk(c[0], c[1], c[2]), 1'($urandom_range(0, 1)), 0,
          $sformatf("rand%0d", it), cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
